ifu_burst: RTL and testbench
============================

IFU_BURST -- requirements
Module: ifu_burst

Interface
REQ-001 Parameter CPU_WIDTH, default 32, data/address width in bits.
REQ-002 Parameter BURST_LEN, default 4, beats per AXI read burst (power of two, 1..16).
REQ-003 Parameter FIFO_DEPTH, default 8, instruction buffer entries (power of two, >= BURST_LEN).
REQ-004 Parameter RESET_PC, default 32'h8000_0000, first fetch address.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_redirect_valid  in  1  flush buffer, restart fetch at i_redirect_pc.
REQ-008 i_redirect_pc  in  CPU_WIDTH  new fetch address, word aligned.
REQ-009 o_post_valid  out  1  buffer head valid.
REQ-010 i_post_ready  in  1  consumer accepts head.
REQ-011 o_instr  out  CPU_WIDTH  head instruction.
REQ-012 o_pc  out  CPU_WIDTH  address of o_instr.
REQ-013 o_fetch_err  out  1  head beat returned non-OKAY rresp (IFU_RRESP_CHK_EN only).
REQ-014 AR channel: arready in 1; arvalid out 1; araddr out CPU_WIDTH; arid out 4; arlen out 8; arsize out 3; arburst out 2.
REQ-015 R channel: rready out 1; rvalid in 1; rresp in 2; rdata in CPU_WIDTH; rlast in 1; rid in 4.
REQ-016 No write channels; the block never writes memory.

Function
REQ-017 FSM states IDLE, ADDR, DATA, DRAIN; no other states.
REQ-018 IDLE->ADDR when free entries (FIFO_DEPTH - count) >= BURST_LEN and no redirect this cycle.
REQ-019 ADDR: arvalid=1, araddr=fetch_pc, arid=0, arlen=BURST_LEN-1, arsize=log2(CPU_WIDTH/8), arburst=2'b01; fields stable until arready.
REQ-020 ADDR->DATA on arvalid&&arready; fetch_pc += BURST_LEN*CPU_WIDTH/8 (modulo 2^CPU_WIDTH), beat_pc = araddr.
REQ-021 DATA: rready=1; each rvalid beat pushes {rdata, beat_pc} into FIFO, beat_pc += CPU_WIDTH/8.
REQ-022 DATA->IDLE on beat with rlast=1; rlast is authoritative, beat count is not checked.
REQ-023 Redirect in IDLE: fetch_pc=i_redirect_pc, FIFO flushed, stay IDLE that cycle.
REQ-024 Redirect in ADDR: arvalid held until arready (AXI rule), fetch_pc=i_redirect_pc, FIFO flushed, then ADDR->DRAIN on handshake.
REQ-025 Redirect in DATA: fetch_pc=i_redirect_pc, FIFO flushed, ->DRAIN; beat in same cycle discarded; if that beat has rlast ->IDLE.
REQ-026 DRAIN: rready=1, beats discarded, ->IDLE on rlast; further redirects only update fetch_pc.
REQ-027 o_post_valid = (count != 0); o_instr/o_pc/o_fetch_err driven from head, combinational from storage.
REQ-028 Pop on o_post_valid&&i_post_ready; simultaneous push and pop leave count unchanged.
REQ-029 Redirect outranks pop and push in same cycle: count becomes 0.
REQ-030 Space check (REQ-018) guarantees no overflow; push while full is a design error flagged by a non-synthesis assertion.
REQ-031 Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.

Reset
REQ-032 On i_rst_n low: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, arvalid=0, rready=0, o_post_valid=0, o_fetch_err=0.
REQ-033 First AR issued in the second cycle after reset release (IDLE->ADDR then arvalid).
REQ-034 Reset mid-burst abandons the burst; the memory side is reset by the same signal.

Configuration
REQ-035 Macro IFU_RRESP_CHK_EN defined: rresp!=2'b00 stored per entry, reported as o_fetch_err with the entry; fetching continues.
REQ-036 Macro IFU_RRESP_CHK_EN undefined: rresp ignored, no error bit stored, o_fetch_err tied 0.

Verification
REQ-037 Reset release, arready=1, memory returns 4 beats -> one AR araddr=0x8000_0000 arlen=3 arsize=2; o_pc 0x8000_0000..0x8000_000C in order.
REQ-038 i_post_ready=0 -> exactly two bursts accepted (8 entries), no third arvalid until 4 pops.
REQ-039 Redirect to 0x8000_0100 during beat 2 of burst -> remaining beats dropped, o_post_valid=0 next cycle, next AR araddr=0x8000_0100 only after rlast.
REQ-040 Redirect while arvalid=1, arready=0 for 3 cycles -> araddr unchanged until handshake, then DRAIN, then AR at redirect address.
REQ-041 Full FIFO, pop and redirect in same cycle -> count=0, no entry delivered.
REQ-042 IFU_RRESP_CHK_EN set, beat 1 rresp=2'b10 -> o_fetch_err=1 only on that entry's pop.

Source files
------------

// File: rtl/ifu_burst.sv
// ifu_burst: instruction fetch unit that refills an instruction FIFO with
// AXI INCR read bursts and presents one instruction per cycle to the core.
// A redirect flushes the buffer and restarts fetching at a new PC. A burst
// that is already in flight is drained and its beats are discarded.
// Optional feature: define IFU_RRESP_CHK_EN to keep a per-entry error bit
// taken from rresp and report it on o_fetch_err.
module ifu_burst #(
    parameter int                   CPU_WIDTH  = 32,
    parameter int                   BURST_LEN  = 4,
    parameter int                   FIFO_DEPTH = 8,
    parameter logic [CPU_WIDTH-1:0] RESET_PC   = 'h8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,

    input  logic                 i_redirect_valid,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,

    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    output logic [CPU_WIDTH-1:0] o_instr,
    output logic [CPU_WIDTH-1:0] o_pc,
    output logic                 o_fetch_err,

    input  logic                 i_arready,
    output logic                 o_arvalid,
    output logic [CPU_WIDTH-1:0] o_araddr,
    output logic [3:0]           o_arid,
    output logic [7:0]           o_arlen,
    output logic [2:0]           o_arsize,
    output logic [1:0]           o_arburst,

    output logic                 o_rready,
    input  logic                 i_rvalid,
    input  logic [1:0]           i_rresp,
    input  logic [CPU_WIDTH-1:0] i_rdata,
    input  logic                 i_rlast,
    input  logic [3:0]           i_rid
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BYTES = CPU_WIDTH / 8;

    localparam logic [CPU_WIDTH-1:0] BEAT_INC   = CPU_WIDTH'(BYTES);
    localparam logic [CPU_WIDTH-1:0] BURST_INC  = CPU_WIDTH'(BURST_LEN * BYTES);
    localparam logic [CNT_W-1:0]     FILL_LIMIT = CNT_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [CNT_W-1:0]     DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]     LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t               r_state;
    logic [CPU_WIDTH-1:0] r_fetchPc;
    logic [CPU_WIDTH-1:0] r_beatPc;
    logic [CPU_WIDTH-1:0] r_araddr;
    logic                 r_arvalid;
    logic                 r_rready;
    logic                 r_redirPending;

    logic [CPU_WIDTH-1:0] r_instrMem [FIFO_DEPTH];
    logic [CPU_WIDTH-1:0] r_pcMem    [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_hasSpace;
    logic                 w_unused;

    assign w_hasSpace = (r_count <= FILL_LIMIT);
    assign w_push     = (r_state == DATA) && i_rvalid && !i_redirect_valid;
    assign w_pop      = o_post_valid && i_post_ready;
    assign w_flush    = i_redirect_valid;

    assign o_arvalid  = r_arvalid;
    assign o_araddr   = r_araddr;
    assign o_arid     = 4'h0;
    assign o_arlen    = 8'(BURST_LEN - 1);
    assign o_arsize   = 3'($clog2(BYTES));
    assign o_arburst  = 2'b01;
    assign o_rready   = r_rready;

    assign o_post_valid = (r_count != '0);
    assign o_instr      = r_instrMem[r_rdPtr];
    assign o_pc         = r_pcMem[r_rdPtr];

    // Fetch sequencer: issues one burst at a time, tracks the fetch and beat PCs, and drains abandoned bursts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_fetchPc      <= RESET_PC;
            r_beatPc       <= '0;
            r_araddr       <= '0;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_redirPending <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_redirect_valid) begin
                        r_fetchPc <= i_redirect_pc;
                    end else if (w_hasSpace) begin
                        r_state   <= ADDR;
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_fetchPc;
                    end
                end
                ADDR: begin
                    if (i_redirect_valid) begin
                        r_fetchPc <= i_redirect_pc;
                    end
                    if (r_arvalid && i_arready) begin
                        r_arvalid      <= 1'b0;
                        r_rready       <= 1'b1;
                        r_redirPending <= 1'b0;
                        if (i_redirect_valid || r_redirPending) begin
                            r_state <= DRAIN;
                        end else begin
                            r_state   <= DATA;
                            r_fetchPc <= r_fetchPc + BURST_INC;
                            r_beatPc  <= r_araddr;
                        end
                    end else if (i_redirect_valid) begin
                        r_redirPending <= 1'b1;
                    end
                end
                DATA: begin
                    if (i_redirect_valid) begin
                        r_fetchPc <= i_redirect_pc;
                        if (i_rvalid && i_rlast) begin
                            r_state  <= IDLE;
                            r_rready <= 1'b0;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else if (i_rvalid) begin
                        r_beatPc <= r_beatPc + BEAT_INC;
                        if (i_rlast) begin
                            r_state  <= IDLE;
                            r_rready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (i_redirect_valid) begin
                        r_fetchPc <= i_redirect_pc;
                    end
                    if (i_rvalid && i_rlast) begin
                        r_state  <= IDLE;
                        r_rready <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
        end
    end

    // Buffer bookkeeping: a redirect empties the buffer and takes priority over any push or pop in that cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage: write the accepted beat and its address at the tail
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_instrMem[r_wrPtr] <= i_rdata;
            r_pcMem[r_wrPtr]    <= r_beatPc;
        end
    end

`ifdef IFU_RRESP_CHK_EN
    logic r_errMem [FIFO_DEPTH];

    // Error storage: remember which beats came back with a non-OKAY response
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_errMem[r_wrPtr] <= (i_rresp != 2'b00);
        end
    end

    assign o_fetch_err = o_post_valid && r_errMem[r_rdPtr];
    assign w_unused    = ^i_rid;
`else
    assign o_fetch_err = 1'b0;
    assign w_unused    = ^{i_rid, i_rresp};
`endif

`ifndef SYNTHESIS
    // Overflow guard: the space check before each burst must make a push into a full buffer impossible
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(w_push && (r_count == DEPTH_CNT)));
        end
    end
`endif

endmodule

// File: tb/tb_ifu_burst.sv
// Directed testbench for ifu_burst using the default parameters. The bench
// acts as the AXI memory: the beat pattern of every burst is driven step by
// step, and each expected value below is worked out by hand.
module tb_ifu_burst;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirValid;
    logic [31:0] redirPc;
    logic        postValid;
    logic        postReady;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fetchErr;
    logic        arready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;

    int total = 0;
    int bad   = 0;

`ifdef IFU_RRESP_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    ifu_burst dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_redirect_valid (redirValid),
        .i_redirect_pc    (redirPc),
        .o_post_valid     (postValid),
        .i_post_ready     (postReady),
        .o_instr          (instr),
        .o_pc             (pc),
        .o_fetch_err      (fetchErr),
        .i_arready        (arready),
        .o_arvalid        (arvalid),
        .o_araddr         (araddr),
        .o_arid           (arid),
        .o_arlen          (arlen),
        .o_arsize         (arsize),
        .o_arburst        (arburst),
        .o_rready         (rready),
        .i_rvalid         (rvalid),
        .i_rresp          (rresp),
        .i_rdata          (rdata),
        .i_rlast          (rlast),
        .i_rid            (4'h0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one R-channel beat (or none) and advance to the next falling edge
    task automatic applyStimulus(input logic rv, input logic rl, input logic [1:0] rr, input logic [31:0] rd);
        rvalid = rv;
        rlast  = rl;
        rresp  = rr;
        rdata  = rd;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        arready    = 1'b0;
        postReady  = 1'b0;
        redirValid = 1'b0;
        redirPc    = 32'h0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        rresp      = 2'b00;
        rdata      = 32'h0;

        @(negedge clk);
        checkOutput("rst_arvalid",   32'(arvalid),   32'h0);
        checkOutput("rst_rready",    32'(rready),    32'h0);
        checkOutput("rst_postvalid", 32'(postValid), 32'h0);
        checkOutput("rst_fetcherr",  32'(fetchErr),  32'h0);

        @(negedge clk);
        rst_n   = 1'b1;
        arready = 1'b1;
        $display("[TB] reset released");

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("ar1_valid", 32'(arvalid), 32'h1);
        checkOutput("ar1_addr",  araddr,       32'h8000_0000);
        checkOutput("ar1_len",   32'(arlen),   32'h3);
        checkOutput("ar1_size",  32'(arsize),  32'h2);
        checkOutput("ar1_burst", 32'(arburst), 32'h1);
        checkOutput("ar1_id",    32'(arid),    32'h0);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("ar1_done_valid", 32'(arvalid), 32'h0);
        checkOutput("data1_rready",   32'(rready),  32'h1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 3), (i == 1) ? 2'b10 : 2'b00, 32'hA000_0000 + 32'(i));
        end
        checkOutput("b1_rready_low", 32'(rready),    32'h0);
        checkOutput("b1_postvalid",  32'(postValid), 32'h1);
        checkOutput("b1_head_pc",    pc,             32'h8000_0000);
        checkOutput("b1_head_instr", instr,          32'hA000_0000);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("ar2_valid", 32'(arvalid), 32'h1);
        checkOutput("ar2_addr",  araddr,       32'h8000_0010);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 3), 2'b00, 32'hB000_0000 + 32'(i));
        end

        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
            checkOutput("full_no_ar", 32'(arvalid), 32'h0);
        end
        checkOutput("full_head_pc", pc, 32'h8000_0000);

        postReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("pop_pc",    pc,              32'h8000_0000 + 32'(4 * i));
            checkOutput("pop_instr", instr,           32'hA000_0000 + 32'(i));
            checkOutput("pop_err",   32'(fetchErr),   (i == 1) ? 32'(ERR_EXP) : 32'h0);
            checkOutput("pop_no_ar", 32'(arvalid),    32'h0);
            applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        end
        postReady = 1'b0;
        checkOutput("after_pop_no_ar", 32'(arvalid), 32'h0);
        checkOutput("after_pop_head",  pc,           32'h8000_0010);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("ar3_valid", 32'(arvalid), 32'h1);
        checkOutput("ar3_addr",  araddr,       32'h8000_0020);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("data3_rready", 32'(rready), 32'h1);
        applyStimulus(1'b1, 1'b0, 2'b00, 32'hC000_0000);
        redirValid = 1'b1;
        redirPc    = 32'h8000_0100;
        applyStimulus(1'b1, 1'b0, 2'b00, 32'hC000_0001);
        redirValid = 1'b0;
        checkOutput("redir_data_postvalid", 32'(postValid), 32'h0);
        checkOutput("redir_data_rready",    32'(rready),    32'h1);
        applyStimulus(1'b1, 1'b0, 2'b00, 32'hC000_0002);
        checkOutput("drain_postvalid", 32'(postValid), 32'h0);
        checkOutput("drain_no_ar",     32'(arvalid),   32'h0);
        arready = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'b00, 32'hC000_0003);
        checkOutput("drain_end_rready",    32'(rready),    32'h0);
        checkOutput("drain_end_no_ar",     32'(arvalid),   32'h0);
        checkOutput("drain_end_postvalid", 32'(postValid), 32'h0);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("ar4_valid", 32'(arvalid), 32'h1);
        checkOutput("ar4_addr",  araddr,       32'h8000_0100);

        redirValid = 1'b1;
        redirPc    = 32'h8000_0200;
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        redirValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("stall_arvalid", 32'(arvalid), 32'h1);
            checkOutput("stall_araddr",  araddr,       32'h8000_0100);
            if (k < 2) begin
                applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
            end
        end

        arready = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("addr_drain_arvalid", 32'(arvalid), 32'h0);
        checkOutput("addr_drain_rready",  32'(rready),  32'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 3), 2'b00, 32'hD000_0000 + 32'(i));
            checkOutput("addr_drain_postvalid", 32'(postValid), 32'h0);
        end
        checkOutput("addr_drain_end_rready", 32'(rready), 32'h0);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("ar5_valid", 32'(arvalid), 32'h1);
        checkOutput("ar5_addr",  araddr,       32'h8000_0200);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 3), 2'b00, 32'hE000_0000 + 32'(i));
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("ar6_valid", 32'(arvalid), 32'h1);
        checkOutput("ar6_addr",  araddr,       32'h8000_0210);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 3), 2'b00, 32'hF000_0000 + 32'(i));
        end
        checkOutput("full2_postvalid", 32'(postValid), 32'h1);
        checkOutput("full2_head_pc",   pc,             32'h8000_0200);
        checkOutput("full2_head_instr", instr,         32'hE000_0000);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("full2_no_ar", 32'(arvalid), 32'h0);

        postReady  = 1'b1;
        redirValid = 1'b1;
        redirPc    = 32'h8000_0300;
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        postReady  = 1'b0;
        redirValid = 1'b0;
        checkOutput("flush_pop_postvalid", 32'(postValid), 32'h0);
        checkOutput("flush_pop_no_ar",     32'(arvalid),   32'h0);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("ar7_valid", 32'(arvalid), 32'h1);
        checkOutput("ar7_addr",  araddr,       32'h8000_0300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
